// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite responder backed by a word-organised SRAM, with wait states and two-cycle ERROR
// Ports: clk/rst (sync, active-high); HSEL/HADDR/HWRITE/HSIZE/HBURST/HTRANS/HPROT/HWDATA/HREADY bus inputs;
//        HREADYOUT/HRESP/HRDATA responder outputs. HBURST and HPROT are ignored.
module ahb_lite_sram_slave #(
  parameter int MEM_WORDS   = 1024,
  parameter int OFFSET_BITS = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_ERR1, S_ERR2} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt, w_cnt;
  logic [AW-1:0] r_word;
  logic [1:0] r_lane, r_size;
  logic r_write;
  logic [31:0] r_mem [MEM_WORDS];
  logic [OFFSET_BITS-1:0] w_off;
  logic [3:0] w_be;
  logic w_accept, w_illegal, w_unused;
  assign w_unused = ^{HBURST, HPROT, HTRANS[0], HADDR[31:OFFSET_BITS]};
  assign w_off = HADDR[OFFSET_BITS-1:0];
  // HREADYOUT in the gate keeps a stray high HREADY during WAIT/ERR1 from clobbering the registered phase
  assign w_accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign w_illegal = (32'(w_off) >= 32'(4 * MEM_WORDS)) | (HSIZE > 3'd2) |
                     (HSIZE == 3'd1 & HADDR[0]) | (HSIZE == 3'd2 & |HADDR[1:0]);
  assign HREADYOUT = !(r_state == S_WAIT || r_state == S_ERR1);
  assign HRESP = {1'b0, r_state == S_ERR1 || r_state == S_ERR2};
  assign HRDATA = r_state == S_ACCESS ? r_mem[r_word] : '0;
  assign w_be = r_size == 2'd0 ? 4'b0001 << r_lane :
                r_size == 2'd1 ? (r_lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_comb begin
    w_next = S_IDLE;
    w_cnt = r_cnt;
    if (r_state == S_WAIT) begin
      w_next = r_cnt == 4'd0 ? S_ACCESS : S_WAIT;
      w_cnt = r_cnt == 4'd0 ? r_cnt : r_cnt - 4'd1;
    end else if (r_state == S_ERR1) begin
      w_next = S_ERR2;
    end else if (w_accept) begin
      w_next = w_illegal ? S_ERR1 : (WAIT_STATES > 0 ? S_WAIT : S_ACCESS);
      w_cnt = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_word <= w_off[AW+1:2];
      r_lane <= HADDR[1:0];
      r_size <= HSIZE[1:0];
      r_write <= HWRITE;
    end
  end
  // array is never reset; a write whose ACCESS edge coincides with rst is dropped
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_ACCESS && r_write)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[r_word][8*i +: 8] <= HWDATA[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: scoreboard bench for two responders (0 and 2 wait states) sharing one bus
module tb_ahb_lite_sram_slave;
  logic clk = 0, rst = 1;
  logic hsel0 = 0, hsel1 = 0, hwrite = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [2:0] hsize = 0, hburst = 0;
  logic [1:0] htrans = 0;
  logic [3:0] hprot = 0;
  logic rdy0, rdy1, hready, dsel = 0;
  logic [1:0] resp0, resp1;
  logic [31:0] rd0, rd1;
  bit cur = 0;
  typedef struct {bit d; bit rdy; bit [1:0] resp; bit chk; bit [31:0] data;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  bit started = 0, done = 0;
  bit [7:0] mb[2][4096];
  bit pend = 0, pd = 0;
  int poff = 0, psz = 0;
  bit [31:0] pwd = 0, nwd = 0;
  always #5 clk = ~clk;
  assign hready = dsel ? rdy1 : rdy0;
  always @(posedge clk) dsel <= rst ? 1'b0 : (hready ? cur : dsel);
  ahb_lite_sram_slave #(.MEM_WORDS(1024), .OFFSET_BITS(16), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HTRANS(htrans), .HPROT(hprot), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0));
  ahb_lite_sram_slave #(.MEM_WORDS(1024), .OFFSET_BITS(16), .WAIT_STATES(2)) u1 (
    .clk(clk), .rst(rst), .HSEL(hsel1), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HTRANS(htrans), .HPROT(hprot), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rd1));
  function automatic exp_t mk(bit d, bit rdy, bit [1:0] resp, bit chk, bit [31:0] data);
    exp_t e;
    e.d = d; e.rdy = rdy; e.resp = resp; e.chk = chk; e.data = data;
    return e;
  endfunction
  function automatic int wordof(int idx);
    return idx < 16 ? idx : 1004 + idx;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic finish_up();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask
  task automatic do_reset(int n);
    repeat (n) begin
      tick();
      rst = 1; hsel0 = 0; hsel1 = 0; htrans = 0;
      while (q.size() > 1) q.delete(q.size() - 1);
      q.push_back(mk(cur, 1, 2'b00, 1, 0));
      started = 1;
      pend = 0;
    end
  endtask
  task automatic xfer(bit d, bit sel, bit [1:0] tr, bit wr, bit [2:0] sz, bit [31:0] a, bit [31:0] wd);
    int n, off;
    bit [31:0] w;
    n = 0;
    tick();
    rst = 0;
    while (!hready) begin
      n++;
      if (n > 20) begin
        total++; bad++;
        $display("FAIL timeout: hready=0 after 20 cycles, want 1");
        finish_up();
      end
      tick();
    end
    hwdata = nwd;
    if (pend) begin
      for (int k = 0; k < psz; k++) mb[pd][poff+k] = pwd[8*((poff+k)%4) +: 8];
      pend = 0;
    end
    cur = d;
    hsel0 = sel && !d; hsel1 = sel && d;
    htrans = tr; hwrite = wr; hsize = sz; haddr = a;
    hburst = 3'($urandom); hprot = 4'($urandom);
    off = int'(a[15:0]);
    if (!sel || !tr[1]) q.push_back(mk(d, 1, 2'b00, 1, 0));
    else if (off >= 4096 || sz > 3'd2 || off % (1 << sz) != 0) begin
      q.push_back(mk(d, 0, 2'b01, 1, 0));
      q.push_back(mk(d, 1, 2'b01, 1, 0));
    end else begin
      repeat (d ? 2 : 0) q.push_back(mk(d, 0, 2'b00, 1, 0));
      w = {mb[d][(off&~3)+3], mb[d][(off&~3)+2], mb[d][(off&~3)+1], mb[d][off&~3]};
      q.push_back(mk(d, 1, 2'b00, !wr, w));
      if (wr) begin
        pend = 1; pd = d; poff = off; psz = 1 << sz; pwd = wd;
      end
    end
    nwd = wd;
  endtask
  initial begin
    exp_t e;
    logic r, orr;
    logic [1:0] s, os;
    logic [31:0] dt, odt;
    wait (started);
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        if (!done) begin
          total++; bad++;
          $display("FAIL underflow: no expectation queued for this cycle");
        end
      end else begin
        e = q.pop_front();
        r = e.d ? rdy1 : rdy0; s = e.d ? resp1 : resp0; dt = e.d ? rd1 : rd0;
        orr = e.d ? rdy0 : rdy1; os = e.d ? resp0 : resp1; odt = e.d ? rd0 : rd1;
        total++;
        if (r !== e.rdy || s !== e.resp || (e.chk && dt !== e.data)) begin
          bad++;
          $display("FAIL resp dut%0d: got rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h%s",
                   e.d, r, s, dt, e.rdy, e.resp, e.data, e.chk ? "" : " (data unchecked)");
        end
        total++;
        if (orr !== 1'b1 || os !== 2'b00 || odt !== 32'h0) begin
          bad++;
          $display("FAIL idle_other dut%0d: got rdy=%b resp=%b data=%h, want rdy=1 resp=00 data=0",
                   !e.d, orr, os, odt);
        end
      end
    end
  end
  initial begin
    bit d, sel, wr;
    bit [1:0] tr;
    bit [2:0] sz;
    int off, lane, rr;
    do_reset(3);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 20; j++)
        xfer(i[0], 1, 2'b10, 1, 3'd2, {16'($urandom), 16'(wordof(j) * 4)}, $urandom);
    xfer(0, 1, 2'b10, 1, 3'd2, 32'h0000_0010, 32'hDEADBEEF);
    xfer(0, 1, 2'b10, 0, 3'd2, 32'h0000_0010, 0);
    xfer(0, 1, 2'b10, 1, 3'd2, 32'h0000_0000, 32'h11223344);
    xfer(0, 1, 2'b10, 1, 3'd0, 32'h0000_0002, 32'h00AA0000);
    xfer(0, 1, 2'b10, 1, 3'd1, 32'h0000_0000, 32'h00005566);
    xfer(0, 1, 2'b10, 0, 3'd2, 32'h0000_0000, 0);
    xfer(1, 1, 2'b10, 0, 3'd2, 32'h0000_0008, 0);
    xfer(1, 1, 2'b11, 0, 3'd2, 32'h0000_0008, 0);
    xfer(0, 1, 2'b10, 0, 3'd2, 32'h0000_1000, 0);
    xfer(0, 1, 2'b10, 1, 3'd2, 32'h0000_0002, 32'hFFFF_FFFF);
    xfer(0, 1, 2'b10, 1, 3'd3, 32'h0000_0000, 32'hFFFF_FFFF);
    xfer(0, 1, 2'b10, 1, 3'd1, 32'h0000_0001, 32'hFFFF_FFFF);
    xfer(0, 1, 2'b10, 0, 3'd2, 32'h0000_0000, 0);
    xfer(0, 1, 2'b00, 1, 3'd2, 32'h0000_0020, 32'hA5A5_0001);
    xfer(0, 1, 2'b01, 1, 3'd2, 32'h0000_0024, 32'hA5A5_0002);
    xfer(0, 0, 2'b10, 1, 3'd2, 32'h0000_0028, 32'hA5A5_0003);
    xfer(0, 1, 2'b10, 1, 3'd2, 32'h0000_002C, 32'hA5A5_0004);
    xfer(0, 0, 2'b11, 1, 3'd2, 32'h0000_0020, 32'hA5A5_0005);
    for (int j = 8; j < 12; j++) xfer(0, 1, 2'b10, 0, 3'd2, 32'(j * 4), 0);
    xfer(1, 1, 2'b10, 1, 3'd2, 32'h0000_0030, 32'h0BAD_F00D);
    tick();
    do_reset(1);
    xfer(1, 1, 2'b10, 0, 3'd2, 32'h0000_0030, 0);
    repeat (400) begin
      d = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9) != 0;
      rr = $urandom_range(0, 9);
      tr = rr < 6 ? 2'b10 : rr < 8 ? 2'b11 : rr == 8 ? 2'b00 : 2'b01;
      sz = $urandom_range(0, 19) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      lane = $urandom_range(0, 3);
      if ($urandom_range(0, 9) != 0) lane = sz == 3'd1 ? lane & 2 : sz == 3'd2 ? 0 : lane;
      off = wordof($urandom_range(0, 19)) * 4 + lane;
      if ($urandom_range(0, 29) == 0) off = $urandom_range(4096, 65535);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) do_reset(1);
      xfer(d, sel, tr, wr, sz, {16'($urandom), 16'(off)}, $urandom);
    end
    repeat (3) xfer(0, 0, 2'b00, 0, 3'd0, 0, 0);
    done = 1;
    for (int n = 0; n < 20 && q.size() > 0; n++) tick();
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    tick();
    finish_up();
  end
endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
AHB-Lite responder (slave) backed by an on-chip word-organised SRAM array. It is the far end of the bus that the AHB-Lite mux drives from the M0 core and the UART debugger. The block decodes address and data phases, performs byte, halfword and word accesses with optional wait states, and returns the two-cycle ERROR response for illegal transfers. HSEL comes from the system address decoder.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the array; power of two, 16..16384.
OFFSET_BITS, 16, number of low HADDR bits examined; upper bits ignored because decode is done by HSEL.
WAIT_STATES, 0, HREADYOUT-low cycles inserted into every legal data phase; range 0..15.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
HSEL  in  1  slave select from the decoder.
HADDR  in  32  transfer address.
HWRITE  in  1  1 = write, 0 = read.
HSIZE  in  3  000 = byte, 001 = halfword, 010 = word; all other values are illegal.
HBURST  in  3  ignored; each beat is decoded individually.
HTRANS  in  2  00 = IDLE, 01 = BUSY, 10 = NONSEQ, 11 = SEQ.
HPROT  in  4  ignored.
HWDATA  in  32  write data, valid in the data phase.
HREADY  in  1  bus-level ready (the mux-returned HREADY).
HREADYOUT  out  1  this slave's ready.
HRESP  out  2  00 = OKAY, 01 = ERROR.
HRDATA  out  32  read data.

Behaviour:
- Address phase is accepted on a clock edge where HSEL=1, HREADY=1 and HTRANS[1]=1. On acceptance the block registers the word offset, byte lane, size and direction.
- IDLE/BUSY transfers, or HSEL=0 with HREADY=1: no access is performed. The next cycle returns a zero-wait OKAY.
- Legality check, done at acceptance:
  - An access is illegal if offset = HADDR[OFFSET_BITS-1:0] >= 4*MEM_WORDS.
  - An access is illegal if HSIZE > 010.
  - An access is illegal if it is a halfword with HADDR[0]=1.
  - An access is illegal if it is a word with HADDR[1:0] != 00.
- State machine (data-phase side):
  - IDLE: HREADYOUT=1, HRESP=00.
  - WAIT: HREADYOUT=0, HRESP=00; a 4-bit counter counts down WAIT_STATES cycles.
  - ACCESS: HREADYOUT=1, HRESP=00; the transfer completes in this cycle.
  - ERR1: HREADYOUT=0, HRESP=01.
  - ERR2: HREADYOUT=1, HRESP=01.
- Transitions:
  - From IDLE, ACCESS or ERR2, the next state is decided by whether an address phase is accepted:
    - Legal access with WAIT_STATES>0: next state WAIT, counter = WAIT_STATES-1.
    - Legal access with WAIT_STATES=0: next state ACCESS.
    - Illegal access: next state ERR1.
    - No accepted address phase: next state IDLE.
  - WAIT goes to ACCESS when the counter reaches 0; otherwise the counter decrements.
  - ERR1 goes to ERR2 unconditionally.
  - No new address phase is accepted while HREADYOUT=0, because the bus HREADY is low then.
- Writes:
  - The array is updated at the clock edge ending ACCESS, using HWDATA sampled in that cycle.
  - Byte lanes are little-endian:
    - Byte: lane HADDR[1:0] is written from HWDATA[8*lane+7:8*lane].
    - Halfword: HADDR[1]=0 writes bytes 0-1; HADDR[1]=1 writes bytes 2-3.
    - Word: all 4 bytes are written.
  - Unselected lanes keep their old value.
  - Errored transfers never write.
- Reads:
  - In ACCESS, HRDATA = the full stored word at the registered offset; the master selects lanes.
  - In every other state HRDATA = 0.
  - Back-to-back write to word N then read of word N: the read data phase returns the newly written value. No forwarding logic is needed, because the write commits before the read's ACCESS cycle.
- Reset (rst=1 at a clock edge):
  - State returns to IDLE and the counter is cleared.
  - HREADYOUT=1, HRESP=00, HRDATA=0.
  - A pending write is discarded.
  - Array contents are not cleared.
  - Reset has priority over every other event, including mid-WAIT and in ERR1.

Test Plan:
1. Reset, WAIT_STATES=0: write word 0xDEADBEEF to 0x0000_0010, then read 0x10 in the next address phase. Required: write data phase HREADYOUT=1, HRESP=00; read data phase HRDATA=0xDEADBEEF with zero waits.
2. Sub-word writes: word 0x0 preset to 0x11223344. Write byte 0xAA at 0x2, then halfword 0x5566 at 0x0 (HWDATA=0x0000_5566). Required: read of 0x0 returns 0x11AA5566.
3. WAIT_STATES=2, word read. Required: HREADYOUT is low for exactly 2 cycles, then high with valid HRDATA and HRESP=00. The next NONSEQ is not accepted until HREADYOUT=1.
4. Illegal transfers: MEM_WORDS=1024, read offset 0x1000, then word access at 0x2, then HSIZE=011. Required for each: ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01). Array is unchanged.
5. IDLE/BUSY/HSEL=0 cycles interleaved with a NONSEQ write. Required: only the NONSEQ modifies memory; all other cycles give HREADYOUT=1, HRESP=00.
6. WAIT_STATES=3 write, rst asserted in the 2nd wait cycle. Required: next cycle HREADYOUT=1, HRESP=00, HRDATA=0; the target word keeps its old value.
